gpio_input_ctrl: RTL
====================

Name: gpio_input_ctrl

Overview:
Conditioning controller for asynchronous external inputs. Per bit, it runs a two-flop synchronizer, then a debouncer paced by one shared prescaler. It accepts a new level after a programmable number of stable samples. Accepted rising/falling edges set sticky, individually clearable status bits that drive a single interrupt line to the SoC interrupt controller.

Parameters:
WIDTH, 8, number of input bits.
DEFAULT, 0, WIDTH-bit reset value of synchronizer flops and o_level.
TICK_DIV, 1000, clock cycles per debounce sample tick; legal range >= 1.
STABLE_TICKS, 4, consecutive differing samples required to accept a new level; legal range >= 1.

Ports:
i_clk  input  1  system clock.
i_rst  input  1  reset.
i_in  input  WIDTH  asynchronous raw inputs.
i_rise_en  input  WIDTH  per-bit enable: an accepted 0->1 sets status.
i_fall_en  input  WIDTH  per-bit enable: an accepted 1->0 sets status.
i_clear  input  WIDTH  write-1-to-clear strobe for o_status, one cycle per write.
o_level  output  WIDTH  debounced, synchronized level.
o_status  output  WIDTH  sticky edge-event flags.
o_irq  output  1  OR-reduction of o_status.

Behaviour:
- Reset: i_rst is synchronous, active-high, clock i_clk. It drives sync stages and o_level to DEFAULT, and prescaler, per-bit counters and o_status to 0. o_irq is therefore 0. Reset mid-debounce discards partial counts.
- Synchronizer: s1 <= i_in; s2 <= s1. Only s2 feeds the debounce logic; i_in is never used combinationally.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = (counter == TICK_DIV-1).
  - TICK_DIV=1 gives tick every cycle.
  - Free-running; not restarted by input activity.
- Per-bit debounce counter cnt, width clog2(STABLE_TICKS+1).
  - No tick: cnt and o_level hold.
  - Tick, s2 == o_level: cnt <= 0.
  - Tick, s2 != o_level, cnt+1 < STABLE_TICKS: cnt <= cnt+1.
  - Tick, s2 != o_level, cnt+1 == STABLE_TICKS: o_level <= s2, cnt <= 0.
  - Any sample that matches o_level before acceptance restarts the count, so glitches shorter than STABLE_TICKS ticks are rejected.
- Latency (TICK_DIV=1): i_in stable before edge 0 -> s2 updated after edge 1 -> o_level updated after edge 1+STABLE_TICKS.
  - For TICK_DIV>1, acceptance occurs on the STABLE_TICKS-th tick after s2 changes.
- Edge events:
  - A bit sets in o_status on the same edge o_level changes, if the matching enable (i_rise_en for 0->1, i_fall_en for 1->0) is high in that cycle.
  - Enables are sampled only at the acceptance edge.
  - Disabled edges update o_level but leave o_status unchanged.
- Clear: o_status[b] <= 0 when i_clear[b]=1. Set and clear of the same bit in one cycle -> set wins (bit stays 1).
- o_irq: combinational OR of o_status registers; no added latency.
- Bits are fully independent except for the shared tick.

Test Plan:
- Reset value: DEFAULT=8'hA5, hold i_rst 3 cycles with i_in=8'h00 -> o_level=8'hA5, o_status=0, o_irq=0 during and immediately after reset.
- Basic accept (WIDTH=8, TICK_DIV=1, STABLE_TICKS=4, i_rise_en=8'hFF), bit0 0->1 before edge 0:
  - o_level[0] is 1 after edge 5, not before.
  - o_status=8'h01 and o_irq=1 from the same edge.
- Glitch reject (TICK_DIV=1, STABLE_TICKS=4): 3-cycle high pulse on bit2 -> o_level and o_status unchanged. A 5-cycle pulse -> o_level[2] rises, then falls 4 cycles after the pulse ends in s2.
- Prescaled timing (TICK_DIV=10, STABLE_TICKS=2), step bit1 -> o_level[1] changes on the second tick after s2 changes; observed delay from i_in edge is 12..21 cycles.
- Enables and clear: i_rise_en=0, i_fall_en=8'h08, toggle bit3 1->0 -> o_status=8'h08. Pulse i_clear=8'h08 -> o_status=0, o_irq=0 next cycle. A rising edge on bit3 sets nothing.
- Set/clear collision: assert i_clear[4] on exactly the acceptance edge of an enabled rise on bit4 -> o_status[4]=1 after that edge.

Source files
------------

// File: rtl/gpio_input_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_input_ctrl: per-bit synchronizer + prescaled debouncer + sticky edge IRQ
// Revision 1.0
// ---------------------------------------------------------------------------
module gpio_input_ctrl #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] DEFAULT      = '0,
   parameter int               TICK_DIV     = 1000,
   parameter int               STABLE_TICKS = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_in,
   input  logic [WIDTH-1:0] i_rise_en,
   input  logic [WIDTH-1:0] i_fall_en,
   input  logic [WIDTH-1:0] i_clear,
   output logic [WIDTH-1:0] o_level,
   output logic [WIDTH-1:0] o_status,
   output logic             o_irq
);

   localparam int              c_PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int              c_CNT_W     = $clog2(STABLE_TICKS + 1);
   localparam logic [c_PRE_W-1:0] c_TICK_LAST   = c_PRE_W'(TICK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_TICKS - 1);

   logic [WIDTH-1:0]              sync1_q, sync2_q;
   logic [c_PRE_W-1:0]            pre_q, pre_d;
   logic                          tick;
   logic [WIDTH-1:0][c_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]              level_q, level_d;
   logic [WIDTH-1:0]              status_q, status_d;

   assign tick  = (pre_q == c_TICK_LAST);
   assign pre_d = tick ? '0 : pre_q + c_PRE_W'(1);

   // Status sets after the clear mask so a same-cycle set wins.
   always_comb begin
      cnt_d    = cnt_q;
      level_d  = level_q;
      status_d = status_q & ~i_clear;
      for (int b = 0; b < WIDTH; b++) begin
         if (tick) begin
            if (sync2_q[b] == level_q[b]) begin
               cnt_d[b] = '0;
            end else if (cnt_q[b] == c_STABLE_LAST) begin
               cnt_d[b]   = '0;
               level_d[b] = sync2_q[b];
               if ((sync2_q[b] && i_rise_en[b]) || (!sync2_q[b] && i_fall_en[b])) begin
                  status_d[b] = 1'b1;
               end
            end else begin
               cnt_d[b] = cnt_q[b] + c_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q  <= DEFAULT;
         sync2_q  <= DEFAULT;
         pre_q    <= '0;
         cnt_q    <= '0;
         level_q  <= DEFAULT;
         status_q <= '0;
      end else begin
         sync1_q  <= i_in;
         sync2_q  <= sync1_q;
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         status_q <= status_d;
      end
   end

   assign o_level  = level_q;
   assign o_status = status_q;
   assign o_irq    = |status_q;

endmodule
`default_nettype wire
